// File: rtl/button_input.sv
// rtl/button_input.sv - debounced push-button front end with press, release and long-press pulses
module button_input #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] BTN,
    output logic [WIDTH-1:0] STATE,
    output logic [WIDTH-1:0] PRESS,
    output logic [WIDTH-1:0] RELEASE,
    output logic [WIDTH-1:0] LONG
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES);
    localparam int HCW = $clog2(LONG_CYCLES) + 1;

    // Last debounce count before a level change is accepted.
    localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    // Hold timer value at which the long-press pulse is requested.
    localparam logic [HCW-1:0] HC_FIRE = HCW'(LONG_CYCLES - 1);
    // Hold timer parks here once the long press has been reported.
    localparam logic [HCW-1:0] HC_SAT  = HCW'(LONG_CYCLES);

    typedef enum logic [1:0] {
        LANE_RELEASED  = 2'd0,
        LANE_PRESSED   = 2'd1,
        LANE_LONG_HELD = 2'd2
    } lane_state_t;

    // Normalise polarity so that 1 always means pressed from here on.
    logic [WIDTH-1:0] pin_pressed;
    assign pin_pressed = ACTIVE_LOW ? ~BTN : BTN;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic           s1;
        logic           s2;
        logic [DCW-1:0] dc;
        logic [HCW-1:0] hc;
        logic           level;
        logic           commit;
        logic           commit_press;
        logic           commit_release;
        logic           hold_hit;
        lane_state_t    lane_q;
        lane_state_t    lane_d;
        logic           press_d;
        logic           release_d;
        logic           long_d;
        logic           press_q;
        logic           release_q;
        logic           long_q;

        // Two-flop synchronizer for the asynchronous pin.
        always_ff @(posedge CLK) begin
            if (RST) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= pin_pressed[i];
                s2 <= s1;
            end
        end

        // The synchronized level has disagreed with the accepted level long enough.
        assign commit         = (s2 != level) && (dc == DC_LAST);
        assign commit_press   = commit && !level;
        assign commit_release = commit && level;
        // A release accepted on the same edge wins over the long-press request.
        assign hold_hit       = level && (hc == HC_FIRE) && !commit_release;

        // Debounce counter: any sample matching the accepted level restarts the count.
        always_ff @(posedge CLK) begin
            if (RST) begin
                dc    <= '0;
                level <= 1'b0;
            end else if (s2 == level) begin
                dc <= '0;
            end else if (dc == DC_LAST) begin
                dc    <= '0;
                level <= s2;
            end else begin
                dc <= dc + 1'b1;
            end
        end

        // Hold timer: counts cycles spent pressed, saturating so the long pulse fires once.
        always_ff @(posedge CLK) begin
            if (RST) begin
                hc <= '0;
            end else if (commit || !level) begin
                hc <= '0;
            end else if (hc != HC_SAT) begin
                hc <= hc + 1'b1;
            end
        end

        // Lane state register.
        always_ff @(posedge CLK) begin
            if (RST) begin
                lane_q <= LANE_RELEASED;
            end else begin
                lane_q <= lane_d;
            end
        end

        // Lane next-state logic.
        always_comb begin
            lane_d = lane_q;
            case (lane_q)
                LANE_RELEASED: begin
                    if (commit_press) begin
                        lane_d = LANE_PRESSED;
                    end
                end
                LANE_PRESSED: begin
                    if (commit_release) begin
                        lane_d = LANE_RELEASED;
                    end else if (hold_hit) begin
                        lane_d = LANE_LONG_HELD;
                    end
                end
                LANE_LONG_HELD: begin
                    if (commit_release) begin
                        lane_d = LANE_RELEASED;
                    end
                end
                default: begin
                    lane_d = LANE_RELEASED;
                end
            endcase
        end

        // Pulse requests decoded from the lane transitions.
        always_comb begin
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            case (lane_q)
                LANE_RELEASED: begin
                    press_d = commit_press;
                end
                LANE_PRESSED: begin
                    release_d = commit_release;
                    long_d    = hold_hit;
                end
                LANE_LONG_HELD: begin
                    release_d = commit_release;
                end
                default: begin
                    press_d = 1'b0;
                end
            endcase
        end

        // Registered one-cycle pulses.
        always_ff @(posedge CLK) begin
            if (RST) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

        assign STATE[i]   = level;
        assign PRESS[i]   = press_q;
        assign RELEASE[i] = release_q;
        assign LONG[i]    = long_q;
    end

endmodule

// File: tb/tb_button_input.sv
// tb/tb_button_input.sv - randomized and directed bench for button_input against a window-based model
module tb_button_input;

    localparam int W  = 4;
    localparam int DB = 4;
    localparam int LC = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] btn = '1;
    logic [W-1:0] btn_hi = '0;
    logic [W-1:0] pressed = '0;

    logic [W-1:0] state_lo, press_lo, release_lo, long_lo;
    logic [W-1:0] state_hi, press_hi, release_hi, long_hi;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model state.
    logic [W-1:0] m_state = '0;
    logic [W-1:0] m_press = '0;
    logic [W-1:0] m_release = '0;
    logic [W-1:0] m_long = '0;
    bit           pq[W][$];
    bit           sq[W][$];
    int           press_edge[W];

    // Observed pulse bookkeeping for the directed scenarios.
    int cnt_press[W];
    int cnt_release[W];
    int cnt_long[W];
    int press_at[W];
    int long_at[W];

    always #5 clk = ~clk;

    button_input #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b1)
    ) dut_lo (
        .CLK(clk), .RST(rst), .BTN(btn),
        .STATE(state_lo), .PRESS(press_lo), .RELEASE(release_lo), .LONG(long_lo)
    );

    button_input #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b0)
    ) dut_hi (
        .CLK(clk), .RST(rst), .BTN(btn_hi),
        .STATE(state_hi), .PRESS(press_hi), .RELEASE(release_hi), .LONG(long_hi)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at edge %0d", tag, got, exp, edge_no);
        end
    endtask

    // A level is accepted once the last DB synchronized samples (each two edges old,
    // none older than the last reset) all differ from it; long fires LC edges after
    // the press was accepted if the lane never left the pressed level.
    task automatic model_edge(input logic r, input logic [W-1:0] pin);
        edge_no++;
        for (int i = 0; i < W; i++) begin
            m_press[i]   = 1'b0;
            m_release[i] = 1'b0;
            m_long[i]    = 1'b0;
            if (r) begin
                pq[i].delete();
                sq[i].delete();
                m_state[i]    = 1'b0;
                press_edge[i] = -100000;
            end else begin
                bit s2v;
                bit flip;
                s2v = (pq[i].size() >= 2) ? pq[i][pq[i].size() - 2] : 1'b0;
                sq[i].push_back(s2v);
                pq[i].push_back(pin[i]);
                if (pq[i].size() > 4) void'(pq[i].pop_front());
                if (sq[i].size() > DB + 2) void'(sq[i].pop_front());
                flip = (sq[i].size() >= DB);
                for (int k = 0; k < DB; k++) begin
                    if (flip && (sq[i][sq[i].size() - 1 - k] == m_state[i])) flip = 1'b0;
                end
                if (!flip && m_state[i] && (edge_no - press_edge[i] == LC)) m_long[i] = 1'b1;
                if (flip) begin
                    if (!m_state[i]) begin
                        m_press[i]    = 1'b1;
                        press_edge[i] = edge_no;
                    end else begin
                        m_release[i] = 1'b1;
                    end
                    m_state[i] = ~m_state[i];
                end
            end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < W; i++) begin
            cnt_press[i]   = 0;
            cnt_release[i] = 0;
            cnt_long[i]    = 0;
            press_at[i]    = -1;
            long_at[i]     = -1;
        end
    endtask

    task automatic step();
        btn    = ~pressed;
        btn_hi = pressed;
        @(posedge clk);
        model_edge(rst, pressed);
        #1;
        check("state_lo",   32'(state_lo),   32'(m_state));
        check("press_lo",   32'(press_lo),   32'(m_press));
        check("release_lo", 32'(release_lo), 32'(m_release));
        check("long_lo",    32'(long_lo),    32'(m_long));
        check("state_hi",   32'(state_hi),   32'(m_state));
        check("press_hi",   32'(press_hi),   32'(m_press));
        check("release_hi", 32'(release_hi), 32'(m_release));
        check("long_hi",    32'(long_hi),    32'(m_long));
        for (int i = 0; i < W; i++) begin
            if (press_lo[i]) begin
                cnt_press[i]++;
                press_at[i] = edge_no;
            end
            if (release_lo[i]) cnt_release[i]++;
            if (long_lo[i]) begin
                cnt_long[i]++;
                long_at[i] = edge_no;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at edge %0d", edge_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_edge;
        int hold_left[W];

        clear_counts();
        rst     = 1'b1;
        pressed = '0;
        run(2);
        check("reset_outputs", 32'({state_lo, press_lo, release_lo, long_lo}), 32'h0);
        rst = 1'b0;
        run(3);

        // Clean press on lane 0: edge 1 is the first to sample the pressed pin.
        pressed[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 5) check("clean_early", 32'({state_lo, press_lo}), 32'h0);
            if (k == 6) check("clean_press_e6", 32'({state_lo, press_lo}), 32'h11);
            if (k == 7) check("clean_press_e7", 32'({state_lo, press_lo}), 32'h10);
        end
        pressed[0] = 1'b0;
        run(10);

        // Bounce on lane 1 while released, then while pressed.
        clear_counts();
        for (int c = 0; c < 20; c++) begin
            pressed[1] = ((c / 2) % 2 == 0);
            step();
        end
        pressed[1] = 1'b0;
        run(10);
        check("bounce_no_press", 32'(cnt_press[1]), 32'd0);
        pressed[1] = 1'b1;
        run(8);
        clear_counts();
        for (int c = 0; c < 20; c++) begin
            pressed[1] = ((c / 2) % 2 == 1);
            step();
        end
        pressed[1] = 1'b1;
        run(6);
        check("bounce_no_release", 32'(cnt_release[1]), 32'd0);
        pressed[1] = 1'b0;
        run(10);

        // Long press on lane 2, then a short press.
        clear_counts();
        pressed[2] = 1'b1;
        run(40);
        pressed[2] = 1'b0;
        run(10);
        check("long_press_cnt", 32'(cnt_press[2]), 32'd1);
        check("long_long_cnt", 32'(cnt_long[2]), 32'd1);
        check("long_delay", 32'(long_at[2] - press_at[2]), 32'(LC));
        check("long_release_cnt", 32'(cnt_release[2]), 32'd1);
        clear_counts();
        pressed[2] = 1'b1;
        run(10);
        pressed[2] = 1'b0;
        run(12);
        check("short_press_cnt", 32'(cnt_press[2]), 32'd1);
        check("short_no_long", 32'(cnt_long[2]), 32'd0);
        check("short_release_cnt", 32'(cnt_release[2]), 32'd1);

        // All lanes pressed together, released staggered.
        pressed = '1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) check("simul_press", 32'(press_lo), 32'hf);
            if (k == 7) check("simul_state", 32'(state_lo), 32'hf);
        end
        for (int i = 0; i < W; i++) begin
            pressed[i] = 1'b0;
            run(2);
        end
        run(12);

        // Reset in the middle of a hold, pin still pressed afterwards.
        clear_counts();
        pressed[0] = 1'b1;
        for (int k = 0; k < 20 && press_lo[0] !== 1'b1; k++) step();
        check("rst_press_seen", 32'(press_lo[0]), 32'd1);
        run(10);
        rst = 1'b1;
        step();
        rst_edge = edge_no;
        rst = 1'b0;
        check("rst_outputs", 32'({state_lo, press_lo, release_lo, long_lo}), 32'h0);
        clear_counts();
        run(30);
        check("rst_repress_cnt", 32'(cnt_press[0]), 32'd1);
        check("rst_repress_delay", 32'(press_at[0] - rst_edge), 32'(DB + 2));
        check("rst_long_delay", 32'(long_at[0] - press_at[0]), 32'(LC));
        pressed[0] = 1'b0;
        run(10);

        // Random lane activity with occasional resets.
        for (int i = 0; i < W; i++) hold_left[i] = $urandom_range(1, 40);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++) begin
                hold_left[i]--;
                if (hold_left[i] <= 0) begin
                    pressed[i]   = ~pressed[i];
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                               : $urandom_range(4, 40);
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
